// File: rtl/ram_sweep_if.sv
// Access bus for ram_sweep: write data, address, write enable and clear
// request from the user; registered read data and sweep status back.
interface ram_sweep_if #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 6
);
  logic [WIDTH-1:0]  in;
  logic [AWIDTH-1:0] add;
  logic              load;
  logic              clr;
  logic [WIDTH-1:0]  o;
  logic              busy;

  modport master (output in, add, load, clr, input o, busy);
  modport slave  (input in, add, load, clr, output o, busy);
endinterface

// File: rtl/ram_sweep.sv
// Parametrised single-port synchronous RAM with registered write-first read
// and a built-in clear engine that zeroes every word after reset or on a
// clr request. busy is high while the sweep runs; user writes are ignored.
module ram_sweep #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 6
) (
  input  logic        clk,
  input  logic        reset,
  ram_sweep_if.slave  bus
);
  localparam int DEPTH = 1 << AWIDTH;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_CLEAR = 1'b1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              state;
  logic [AWIDTH-1:0] ptr;
  logic [WIDTH-1:0]  o_q;

  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  // Select the single write per edge: sweep zeroing or a user write.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.add;
    mem_wdata = bus.in;
    if (!reset) begin
      if (state == STATE_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
      end else if (!bus.clr && bus.load) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; the clear engine gives it a known state,
  // which keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Clear-engine state, sweep pointer and registered read port.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATE_CLEAR;
      ptr   <= '0;
      o_q   <= '0;
    end else if (state == STATE_CLEAR) begin
      o_q <= '0;
      ptr <= ptr + 1'b1;
      if (ptr == {AWIDTH{1'b1}}) begin
        state <= STATE_IDLE;
      end
    end else if (bus.clr) begin
      state <= STATE_CLEAR;
      ptr   <= '0;
      o_q   <= '0;
    end else if (bus.load) begin
      o_q <= bus.in;
    end else begin
      o_q <= mem[bus.add];
    end
  end

  assign bus.o    = o_q;
  assign bus.busy = (state == STATE_CLEAR);
endmodule

// File: doc/ram_sweep.md
# ram_sweep

Parametrised synchronous RAM, the next generation of the fixed 16-bit × 64 word store. Word width and address width are set by parameters. The read port is registered with write-first behaviour. A built-in clear engine zeroes every word after reset or on request, and a `busy` flag reports when the clear is in progress. It sits wherever the datapath needs a word-addressed store of arbitrary geometry that must start from a known all-zero state.

## Interface
- `WIDTH`, default 16: data word width in bits, ≥1.
- `AWIDTH`, default 6: address width in bits, ≥1; DEPTH = 2^AWIDTH words.

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; starts a clear sweep.
- `in` input WIDTH: write data.
- `add` input AWIDTH: word address, used for both read and write.
- `load` input 1: write enable.
- `clr` input 1: clear request; honoured only in IDLE.
- `o` output WIDTH: registered read data.
- `busy` output 1: high while the clear sweep runs; writes are ignored while high.

## Operation
- Storage: DEPTH × WIDTH register array. An AWIDTH-bit sweep pointer `ptr` and a one-bit state hold the engine status.
- States:
  - CLEAR: sweep in progress, `busy`=1.
  - IDLE: normal access, `busy`=0.
- `reset` high at an edge (any state):
  - State goes to CLEAR, `ptr` to 0, `o` to 0, `busy` to 1.
  - No memory word is written on that edge.
  - Reset is held as long as `reset` stays high; `ptr` remains 0.
- CLEAR, `reset` low:
  - Each edge writes 0 to mem[`ptr`], drives `o` to 0, and advances `ptr` by 1.
  - On the edge that writes mem[DEPTH-1], `ptr` wraps to 0 and the state goes to IDLE. `busy` reads 0 after that edge.
  - `load` and `clr` are ignored throughout CLEAR.
- IDLE, `clr`=1:
  - State goes to CLEAR, `ptr` to 0, `busy` to 1.
  - No write occurs on that edge, even if `load`=1; `clr` wins.
  - `o` is driven to 0 on that edge.
- IDLE, `clr`=0, `load`=1: mem[`add`] ← `in`, and `o` ← `in` (write-first).
- IDLE, `clr`=0, `load`=0: `o` ← mem[`add`].
- Address arithmetic is modulo DEPTH. There is no out-of-range case.

## Timing
- Reset values: `o`=0, `busy`=1. Memory contents are undefined until the sweep completes.
- Sweep length: exactly DEPTH edges with `reset` low. The sweep is the same after a `clr` request, counted from the edge after the `clr` edge.
- Read latency is 1 edge: `add` presented before edge N gives mem[`add`] on `o` after edge N.
- Write: the new value is visible on `o` after the same edge (write-first), and to any later read of that address.
- Back-to-back writes and reads at full rate, one per cycle, with no bubbles in IDLE.
- Reset mid-sweep: the sweep restarts from `ptr`=0 and takes a full DEPTH edges again. Words already cleared stay 0.
- Reset and `clr` asserted together: reset semantics apply.

## Test plan
All scenarios use WIDTH=16, AWIDTH=6 unless noted.

1. Reset for 2 cycles, then release.
   - `busy`=1 for exactly 64 edges, then 0.
   - `o`=0 throughout.
   - Read of addresses 0, 31 and 63 afterwards returns 0x0000.
2. IDLE write/read.
   - load 0xBEEF to add 5: `o`=0xBEEF after the same edge.
   - Read add 5 two cycles later: `o`=0xBEEF one edge after the address is presented.
   - Read add 6: 0x0000.
3. Writes during the sweep.
   - `load`=1 with 0x1234 to add 10 while `busy`=1.
   - Once `busy`=0, reading add 10 returns 0x0000.
4. Clear request.
   - Write 0xFFFF to add 63 and 0x00A5 to add 0, then pulse `clr`.
   - `busy`=1 for 64 edges.
   - Both addresses then read 0x0000.
5. Simultaneous events.
   - In IDLE with add 12 holding 0x0F0F, assert `load`=1 (0xAAAA, add 12) and `clr`=1 together.
   - Sweep starts and the write is dropped; add 12 reads 0x0000 after the sweep.
   - Reset asserted when `ptr`=30: `busy` stays high for 64 edges after release.
6. Small geometry, WIDTH=8, AWIDTH=3.
   - After reset, `busy` falls after 8 edges.
   - Write 0x7E to add 7, then read add 7: `o`=0x7E.
   - Read add 0: 0x00.
